// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - scan state encoding, code-width helper and event record layout
package key_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_OFF,
    ST_SETTLE,
    ST_REL,
    ST_EVAL
  } scan_state_e;

  // Cycles with the LCD pins tri-stated before a column is driven.
  localparam int OFF_CYCLES = 2;

  // Event records are packed {press, code}: press sits just above the code field.
  function automatic int ev_press_bit(input int cw);
    return cw;
  endfunction

  // Bits needed to index n items, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO; a full FIFO accepts a push when popped in the same cycle
module sync_fifo
  import key_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    out_tvalid = (cnt_q != '0);
    out_tdata  = mem_q[rd_q];
    pop        = out_tvalid && out_tready;
    in_tready  = (cnt_q != FULL_CNT) || pop;
    push       = in_tvalid && in_tready;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (push) begin
      mem_d[wr_q] = in_tdata;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - keyboard matrix scanner sharing the LCD data bus
// Borrows the bus once per period, samples one column, then debounces its rows one per cycle.
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter int COLS       = 9,
  parameter int ROWS       = 8,
  parameter int SETTLE     = 500,
  parameter int PERIOD     = 4096,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8,
  localparam int CW        = clog2(COLS * ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 bus_req,
  input  logic                 bus_idle,
  output logic                 lcd_oe,
  output logic [COLS-1:0]      col_drive,
  input  logic [ROWS-1:0]      row_in,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 ev_press,
  output logic [CW-1:0]        ev_code,
  output logic [COLS*ROWS-1:0] key_down
);

  localparam int NK  = COLS * ROWS;
  localparam int CLW = clog2(COLS);
  localparam int RW  = clog2(ROWS);
  localparam int PW  = clog2(PERIOD);
  localparam int TW  = clog2(SETTLE + ROWS + OFF_CYCLES);
  localparam int PB  = ev_press_bit(CW);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  scan_state_e     state_q, state_d;
  logic [PW-1:0]   per_q, per_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [ROWS-1:0] samp_q, samp_d;
  logic [NK-1:0]   key_down_q, key_down_d;
  logic [3:0]      dcnt_q [NK];
  logic [3:0]      dcnt_d [NK];

  logic            wrap;
  logic [RW-1:0]   row;
  int              key_i;
  logic [CW-1:0]   key;
  logic            sample;
  logic [3:0]      run;
  logic            push_valid, push_ready;
  logic [CW:0]     push_data, pop_data;

  assign wrap = (per_q == PW'(PERIOD - 1));

  always_comb begin
    state_d    = state_q;
    per_d      = wrap ? '0 : per_q + PW'(1);
    col_d      = col_q;
    tmr_d      = tmr_q;
    samp_d     = samp_q;
    key_down_d = key_down_q;
    dcnt_d     = dcnt_q;
    bus_req    = 1'b0;
    lcd_oe     = 1'b1;
    col_drive  = '1;
    push_valid = 1'b0;
    push_data  = '0;
    row        = tmr_q[RW-1:0];
    key_i      = int'(col_q) * ROWS + int'(row);
    key        = CW'(key_i);
    sample     = samp_q[row];
    run        = '0;

    case (state_q)
      ST_IDLE: begin
        if (wrap) state_d = ST_REQ;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_idle) begin
          state_d = ST_OFF;
          tmr_d   = '0;
        end
      end
      ST_OFF: begin
        bus_req = 1'b1;
        lcd_oe  = 1'b0;
        tmr_d   = tmr_q + TW'(1);
        if (tmr_q == TW'(OFF_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          tmr_d   = '0;
        end
      end
      ST_SETTLE: begin
        bus_req          = 1'b1;
        lcd_oe           = 1'b0;
        col_drive[col_q] = 1'b0;
        tmr_d            = tmr_q + TW'(1);
        if (tmr_q == TW'(SETTLE - 1)) begin
          samp_d  = ~row_in;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        state_d = ST_EVAL;
        tmr_d   = '0;
      end
      ST_EVAL: begin
        if (sample == key_down_q[key]) begin
          dcnt_d[key] = '0;
        end else begin
          run         = (dcnt_q[key] == DB) ? DB : dcnt_q[key] + 4'd1;
          dcnt_d[key] = run;
          // A refused push leaves the count saturated so the next scan retries it.
          if (run == DB) begin
            push_valid = 1'b1;
            push_data  = {sample, key};
            if (push_ready) begin
              key_down_d[key] = sample;
              dcnt_d[key]     = '0;
            end
          end
        end
        if (tmr_q == TW'(ROWS - 1)) begin
          state_d = ST_IDLE;
          col_d   = (col_q == CLW'(COLS - 1)) ? '0 : col_q + CLW'(1);
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      per_q      <= '0;
      col_q      <= '0;
      tmr_q      <= '0;
      samp_q     <= '0;
      key_down_q <= '0;
      dcnt_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      col_q      <= col_d;
      tmr_q      <= tmr_d;
      samp_q     <= samp_d;
      key_down_q <= key_down_d;
      dcnt_q     <= dcnt_d;
    end
  end

  sync_fifo #(
    .WIDTH(CW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (push_data),
    .in_tvalid (push_valid),
    .in_tready (push_ready),
    .out_tdata (pop_data),
    .out_tvalid(ev_valid),
    .out_tready(ev_ready)
  );

  assign ev_press = pop_data[PB];
  assign ev_code  = pop_data[CW-1:0];
  assign key_down = key_down_q;

endmodule
